id_scoreboard: RTL and testbench

//  Register-hazard scheduler for the ID stage. Tracks outstanding register writes

---
 rtl/id_scoreboard.sv | 98 +++++++++
 tb/tb_id_scoreboard.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/id_scoreboard.sv
// ID-stage RAW hazard scoreboard: per-register pending-write counters, retired by WB writes.
// Issue/stall decision is combinational (zero latency); ex_ready_in low or a hazard withholds issue.
module id_scoreboard #(
  parameter int RADDR_WIDTH = 5,
  parameter int NUM_REGS    = 32,
  parameter int PEND_WIDTH  = 2,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid_in,
  input  logic                   reg1_renable_in,
  input  logic [RADDR_WIDTH-1:0] reg1_raddr_in,
  input  logic                   reg2_renable_in,
  input  logic [RADDR_WIDTH-1:0] reg2_raddr_in,
  input  logic                   reg_wenable_in,
  input  logic [RADDR_WIDTH-1:0] reg_waddr_in,
  input  logic                   ex_ready_in,
  input  logic                   wb_wenable_in,
  input  logic [RADDR_WIDTH-1:0] wb_waddr_in,
  input  logic                   flush_in,
  output logic                   issue_out,
  output logic                   stall_out,
  output logic [NUM_REGS-1:0]    busy_vec_out,
  output logic                   err_out,
  output logic [STALL_CNT_W-1:0] stall_cnt_out
);

  localparam logic [PEND_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [PEND_WIDTH-1:0] CNT_ONE = PEND_WIDTH'(1);

  logic [PEND_WIDTH-1:0] cnt     [NUM_REGS];
  logic [PEND_WIDTH-1:0] cnt_nxt [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_nxt;
  logic [NUM_REGS-1:0]   inc_vec;
  logic [NUM_REGS-1:0]   dec_vec;
  logic                  raw;
  logic                  sat;
  logic                  err_set;

  // Write-first regfile: a last outstanding write retiring this cycle is visible to the reader.
  function automatic logic resolved(input logic [PEND_WIDTH-1:0]  c,
                                    input logic [RADDR_WIDTH-1:0] a,
                                    input logic                   wb_en,
                                    input logic [RADDR_WIDTH-1:0] wb_a);
    return (c == '0) || ((c == CNT_ONE) && wb_en && (wb_a == a));
  endfunction

  always_comb begin
    raw = (reg1_renable_in && (reg1_raddr_in != '0) &&
           !resolved(cnt[reg1_raddr_in], reg1_raddr_in, wb_wenable_in, wb_waddr_in)) ||
          (reg2_renable_in && (reg2_raddr_in != '0) &&
           !resolved(cnt[reg2_raddr_in], reg2_raddr_in, wb_wenable_in, wb_waddr_in));
    sat = reg_wenable_in && (reg_waddr_in != '0) && (cnt[reg_waddr_in] == CNT_MAX) &&
          !(wb_wenable_in && (wb_waddr_in == reg_waddr_in));
    issue_out = !rst && id_valid_in && ex_ready_in && !flush_in && !raw && !sat;
    stall_out = !rst && id_valid_in && !issue_out;
  end

  always_comb begin
    err_set  = 1'b0;
    busy_nxt = '0;
    inc_vec  = '0;
    dec_vec  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_nxt[i] = '0;
      if (i != 0) begin
        inc_vec[i] = issue_out && reg_wenable_in && (reg_waddr_in == i[RADDR_WIDTH-1:0]);
        dec_vec[i] = wb_wenable_in && (wb_waddr_in == i[RADDR_WIDTH-1:0]);
        cnt_nxt[i] = cnt[i];
        if (flush_in) begin
          cnt_nxt[i] = '0;
        end else if (inc_vec[i] && !dec_vec[i]) begin
          cnt_nxt[i] = cnt[i] + CNT_ONE;
        end else if (dec_vec[i] && !inc_vec[i]) begin
          if (cnt[i] != '0) cnt_nxt[i] = cnt[i] - CNT_ONE;
          else              err_set    = 1'b1;
        end
      end
      busy_nxt[i] = (cnt_nxt[i] != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
      busy_vec_out  <= '0;
      err_out       <= 1'b0;
      stall_cnt_out <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) cnt[i] <= cnt_nxt[i];
      busy_vec_out <= busy_nxt;
      if (err_set) err_out <= 1'b1;
      if (stall_out && (stall_cnt_out != '1)) stall_cnt_out <= stall_cnt_out + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_scoreboard.sv
// Directed bench for id_scoreboard: hazard stall/bypass, saturation, underflow, flush and reset.
module tb_id_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid_in, reg1_renable_in, reg2_renable_in, reg_wenable_in;
  logic [4:0]  reg1_raddr_in, reg2_raddr_in, reg_waddr_in, wb_waddr_in;
  logic        ex_ready_in, wb_wenable_in, flush_in;
  logic        issue_out, stall_out, err_out;
  logic [31:0] busy_vec_out;
  logic [15:0] stall_cnt_out;

  int n_chk  = 0;
  int n_err  = 0;
  int exp_sc = 0;

  always #5 clk = ~clk;

  id_scoreboard dut (
    .clk(clk), .rst(rst), .id_valid_in(id_valid_in),
    .reg1_renable_in(reg1_renable_in), .reg1_raddr_in(reg1_raddr_in),
    .reg2_renable_in(reg2_renable_in), .reg2_raddr_in(reg2_raddr_in),
    .reg_wenable_in(reg_wenable_in), .reg_waddr_in(reg_waddr_in),
    .ex_ready_in(ex_ready_in), .wb_wenable_in(wb_wenable_in), .wb_waddr_in(wb_waddr_in),
    .flush_in(flush_in), .issue_out(issue_out), .stall_out(stall_out),
    .busy_vec_out(busy_vec_out), .err_out(err_out), .stall_cnt_out(stall_cnt_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic v, input logic r1e, input logic [4:0] r1,
                     input logic r2e, input logic [4:0] r2,
                     input logic we, input logic [4:0] wa, input logic er,
                     input logic wbe, input logic [4:0] wba, input logic fl);
    id_valid_in = v;   reg1_renable_in = r1e; reg1_raddr_in = r1;
    reg2_renable_in = r2e; reg2_raddr_in = r2;
    reg_wenable_in = we;   reg_waddr_in = wa;  ex_ready_in = er;
    wb_wenable_in = wbe;   wb_waddr_in = wba;  flush_in = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic ei, input logic es);
    #1;
    chk({tag, ".issue"}, {31'b0, issue_out}, {31'b0, ei});
    chk({tag, ".stall"}, {31'b0, stall_out}, {31'b0, es});
    if (es) exp_sc++;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    drv(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    #2;
    chk("rst.issue", {31'b0, issue_out}, 32'd0);
    chk("rst.stall", {31'b0, stall_out}, 32'd0);
    chk("rst.busy", busy_vec_out, 32'd0);
    chk("rst.err", {31'b0, err_out}, 32'd0);
    chk("rst.sc", {16'b0, stall_cnt_out}, 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // x0 reads and writes never create hazards
    drv(1, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0);
    repeat (3) begin
      step("x0", 1, 0);
      chk("x0.busy", busy_vec_out, 32'd0);
    end

    // RAW on x5, then same-cycle WB bypass
    drv(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0);
    step("wr5", 1, 0);
    chk("wr5.busy", busy_vec_out, 32'h20);
    drv(1, 1, 5, 0, 0, 1, 6, 1, 0, 0, 0);
    step("raw5a", 0, 1);
    step("raw5b", 0, 1);
    chk("raw5.sc", {16'b0, stall_cnt_out}, 32'd2);
    chk("raw5.busy", busy_vec_out, 32'h20);
    drv(1, 1, 5, 0, 0, 1, 6, 1, 1, 5, 0);
    step("byp5", 1, 0);
    chk("byp5.busy", busy_vec_out, 32'h40);
    drv(0, 0, 0, 0, 0, 0, 0, 1, 1, 6, 0);
    step("wb6", 0, 0);
    chk("wb6.busy", busy_vec_out, 32'd0);

    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("exrdy", 0, 1);
    chk("exrdy.sc", {16'b0, stall_cnt_out}, 32'd3);
    chk("exrdy.busy", busy_vec_out, 32'd0);

    // Saturation on x7
    drv(1, 0, 0, 0, 0, 1, 7, 1, 0, 0, 0);
    repeat (3) step("wr7", 1, 0);
    chk("wr7.busy", busy_vec_out, 32'h80);
    step("sat7", 0, 1);
    drv(1, 0, 0, 0, 0, 1, 7, 1, 1, 7, 0);
    step("sat7wb", 1, 0);
    chk("sat7wb.busy", busy_vec_out, 32'h80);
    drv(0, 0, 0, 0, 0, 0, 0, 1, 1, 7, 0);
    step("wb7a", 0, 0);
    chk("wb7a.busy", busy_vec_out, 32'h80);
    step("wb7b", 0, 0);
    chk("wb7b.busy", busy_vec_out, 32'h80);
    step("wb7c", 0, 0);
    chk("wb7c.busy", busy_vec_out, 32'd0);
    chk("wb7c.err", {31'b0, err_out}, 32'd0);
    chk("sat7.sc", {16'b0, stall_cnt_out}, exp_sc);

    // inc+dec on x9, then underflow
    drv(1, 0, 0, 0, 0, 1, 9, 1, 0, 0, 0);
    step("wr9", 1, 0);
    chk("wr9.busy", busy_vec_out, 32'h200);
    drv(1, 0, 0, 0, 0, 1, 9, 1, 1, 9, 0);
    step("wr9wb", 1, 0);
    chk("wr9wb.busy", busy_vec_out, 32'h200);
    drv(0, 0, 0, 0, 0, 0, 0, 1, 1, 9, 0);
    step("wb9", 0, 0);
    chk("wb9.busy", busy_vec_out, 32'd0);
    chk("wb9.err", {31'b0, err_out}, 32'd0);
    drv(0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0);
    step("wbx0", 0, 0);
    chk("wbx0.err", {31'b0, err_out}, 32'd0);
    drv(0, 0, 0, 0, 0, 0, 0, 1, 1, 9, 0);
    step("uflow", 0, 0);
    chk("uflow.err", {31'b0, err_out}, 32'd1);
    drv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step("sticky", 0, 0);
    chk("sticky.err", {31'b0, err_out}, 32'd1);

    // Asynchronous reset mid-run with cnt[5]=2
    drv(1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0);
    step("wr5x2a", 1, 0);
    step("wr5x2b", 1, 0);
    chk("wr5x2.busy", busy_vec_out, 32'h20);
    drv(1, 1, 5, 0, 0, 0, 0, 1, 0, 0, 0);
    #1;
    rst = 1'b1;
    #1;
    chk("arst.busy", busy_vec_out, 32'd0);
    chk("arst.err", {31'b0, err_out}, 32'd0);
    chk("arst.sc", {16'b0, stall_cnt_out}, 32'd0);
    chk("arst.issue", {31'b0, issue_out}, 32'd0);
    chk("arst.stall", {31'b0, stall_out}, 32'd0);
    exp_sc = 0;
    tick();
    rst = 1'b0;
    step("postrst", 1, 0);
    chk("postrst.busy", busy_vec_out, 32'd0);

    // Flush with cnt[3]=2, cnt[4]=1 and WB x3 in the flush cycle
    drv(1, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0);
    step("wr3a", 1, 0);
    step("wr3b", 1, 0);
    drv(1, 0, 0, 0, 0, 1, 4, 1, 0, 0, 0);
    step("wr4", 1, 0);
    chk("wr34.busy", busy_vec_out, 32'h18);
    drv(1, 1, 3, 0, 0, 0, 0, 1, 1, 3, 0);
    step("rd3cnt2", 0, 1);
    chk("rd3cnt2.busy", busy_vec_out, 32'h18);
    drv(1, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0);
    step("wr3c", 1, 0);
    drv(1, 0, 0, 1, 4, 0, 0, 1, 0, 0, 0);
    step("rs2_4", 0, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 1, 1, 10, 0);
    step("uflow10", 0, 0);
    chk("uflow10.err", {31'b0, err_out}, 32'd1);
    drv(1, 0, 0, 0, 0, 1, 3, 1, 1, 3, 1);
    step("flush", 0, 1);
    chk("flush.busy", busy_vec_out, 32'd0);
    chk("flush.err", {31'b0, err_out}, 32'd1);
    drv(1, 1, 3, 1, 4, 0, 0, 1, 0, 0, 0);
    step("postfl", 1, 0);
    chk("postfl.sc", {16'b0, stall_cnt_out}, exp_sc);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
